// File: rtl/cpu_loader_pkg.sv
// Shared encodings for the CPU program/state loader: packet targets,
// FSM states and header field layout.
package cpu_loader_pkg;

    typedef enum logic [1:0] {
        TGT_IMEM = 2'b00,
        TGT_DMEM = 2'b01,
        TGT_REG  = 2'b10,
        TGT_GO   = 2'b11
    } tgt_e;

    typedef enum logic [1:0] {
        S_HDR  = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_RUN  = 2'b11
    } state_e;

    // Header layout: target in the top two bits, count in the low CNT_W bits
    localparam int TGT_W      = 2;
    localparam int REG_ADDR_W = 4;

endpackage

// File: rtl/cpu_loader_wr_port.sv
// Registered write stage: turns one data-beat request into a single-cycle,
// one-hot strobe on the IMEM, DMEM or register-file write group.
module cpu_loader_wr_port
    import cpu_loader_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fire,
    input  tgt_e               tgt,
    input  logic [DATA_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               reg_we,
    output logic [REG_ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0]  reg_wdata
);

    // Upper address bits beyond each target's width simply wrap away
    logic unused_addr;
    assign unused_addr = ^addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            reg_we     <= 1'b0;
            reg_waddr  <= '0;
            reg_wdata  <= '0;
        end else begin
            imem_we <= fire && (tgt == TGT_IMEM);
            dmem_we <= fire && (tgt == TGT_DMEM);
            reg_we  <= fire && (tgt == TGT_REG);
            if (fire && tgt == TGT_IMEM) begin
                imem_addr  <= addr[IADDR_W-1:0];
                imem_wdata <= wdata;
            end
            if (fire && tgt == TGT_DMEM) begin
                dmem_addr  <= addr[DADDR_W-1:0];
                dmem_wdata <= wdata;
            end
            if (fire && tgt == TGT_REG) begin
                reg_waddr <= addr[REG_ADDR_W-1:0];
                reg_wdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/cpu_loader.sv
// Boot/program loader: parses framed packets from a valid/ready word stream,
// writes IMEM, DMEM and the register file, then releases the CPU on GO.
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 8,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               reg_we,
    output logic [3:0]         reg_waddr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               cpu_hold,
    output logic               busy
);

    state_e            state_q, state_d;
    tgt_e              tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              ready_q;
    logic              accept;
    logic              fire;

    assign accept   = in_valid && ready_q;
    assign in_ready = ready_q;
    assign cpu_hold = (state_q != S_RUN);
    assign busy     = (state_q == S_ADDR) || (state_q == S_DATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HDR;
            tgt_q   <= TGT_IMEM;
            cnt_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= (state_d != S_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        fire    = 1'b0;
        if (accept) begin
            case (state_q)
                S_HDR: begin
                    tgt_d   = tgt_e'(in_data[DATA_W-1 -: TGT_W]);
                    cnt_d   = in_data[CNT_W-1:0];
                    state_d = (tgt_d == TGT_GO) ? S_RUN : S_ADDR;
                end
                S_ADDR: begin
                    addr_d = in_data;
                    // Memories are word-addressed on even byte addresses
                    if (tgt_q != TGT_REG) addr_d[0] = 1'b0;
                    state_d = (cnt_q == '0) ? S_HDR : S_DATA;
                end
                S_DATA: begin
                    fire   = 1'b1;
                    addr_d = addr_q + ((tgt_q == TGT_REG) ? DATA_W'(1) : DATA_W'(2));
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_HDR;
                end
                default: ;
            endcase
        end
    end

    cpu_loader_wr_port #(
        .DATA_W  (DATA_W),
        .IADDR_W (IADDR_W),
        .DADDR_W (DADDR_W)
    ) u_wr_port (
        .clk        (clk),
        .reset      (reset),
        .fire       (fire),
        .tgt        (tgt_q),
        .addr       (addr_q),
        .wdata      (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .reg_we     (reg_we),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata)
    );

endmodule

// File: tb/tb_cpu_loader.sv
// Directed table-driven bench for cpu_loader with a small memory/regfile model.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        imem_we, dmem_we, reg_we;
    logic [7:0]  imem_addr, dmem_addr;
    logic [3:0]  reg_waddr;
    logic [15:0] imem_wdata, dmem_wdata, reg_wdata;
    logic        cpu_hold, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .cpu_hold(cpu_hold), .busy(busy)
    );

    // Memory model: big-endian DMEM bytes, register file
    logic [7:0]  dm [256];
    logic [15:0] rf [16];
    int          imem_writes = 0;

    always @(posedge clk) begin
        if (dmem_we) begin
            dm[dmem_addr]              <= dmem_wdata[15:8];
            dm[8'(dmem_addr + 8'd1)]   <= dmem_wdata[7:0];
        end
        if (reg_we) rf[reg_waddr] <= reg_wdata;
        if (imem_we) imem_writes <= imem_writes + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // we field is {reg, dmem, imem}
    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [2:0]  we;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic        busy;
    } vec_t;

    function automatic vec_t mk(logic v, logic [15:0] d, logic [2:0] we,
                                logic [7:0] a, logic [15:0] wd, logic b);
        vec_t r;
        r.v = v; r.d = d; r.we = we; r.addr = a; r.wd = wd; r.busy = b;
        return r;
    endfunction

    task automatic step(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t t);
        string s;
        s = $sformatf("row%0d", i);
        chk({s, ".we"}, {reg_we, dmem_we, imem_we}, t.we);
        chk({s, ".busy"}, busy, t.busy);
        chk({s, ".ready"}, in_ready, 1);
        chk({s, ".hold"}, cpu_hold, 1);
        if (t.we[0]) begin
            chk({s, ".iaddr"}, imem_addr, t.addr);
            chk({s, ".idata"}, imem_wdata, t.wd);
        end
        if (t.we[1]) begin
            chk({s, ".daddr"}, dmem_addr, t.addr);
            chk({s, ".ddata"}, dmem_wdata, t.wd);
        end
        if (t.we[2]) begin
            chk({s, ".raddr"}, {4'h0, reg_waddr}, t.addr);
            chk({s, ".rdata"}, reg_wdata, t.wd);
        end
    endtask

    vec_t tbl[29];

    initial begin
        // IMEM load of three words at 0x10
        tbl[0]  = mk(1, 16'h0003, 3'b000, 8'h00, 16'h0000, 1);
        tbl[1]  = mk(1, 16'h0010, 3'b000, 8'h00, 16'h0000, 1);
        tbl[2]  = mk(1, 16'hA1B2, 3'b001, 8'h10, 16'hA1B2, 1);
        tbl[3]  = mk(1, 16'hC3D4, 3'b001, 8'h12, 16'hC3D4, 1);
        tbl[4]  = mk(1, 16'hE5F6, 3'b001, 8'h14, 16'hE5F6, 0);
        tbl[5]  = mk(0, 16'h0000, 3'b000, 8'h00, 16'h0000, 0);
        // DMEM odd address forced even, then wrap to 0
        tbl[6]  = mk(1, 16'h4002, 3'b000, 8'h00, 16'h0000, 1);
        tbl[7]  = mk(1, 16'h00FF, 3'b000, 8'h00, 16'h0000, 1);
        tbl[8]  = mk(1, 16'h1234, 3'b010, 8'hFE, 16'h1234, 1);
        tbl[9]  = mk(1, 16'h5678, 3'b010, 8'h00, 16'h5678, 0);
        // REG wrap R15 -> R0
        tbl[10] = mk(1, 16'h8002, 3'b000, 8'h00, 16'h0000, 1);
        tbl[11] = mk(1, 16'h000F, 3'b000, 8'h00, 16'h0000, 1);
        tbl[12] = mk(1, 16'h1111, 3'b100, 8'h0F, 16'h1111, 1);
        tbl[13] = mk(1, 16'h2222, 3'b100, 8'h00, 16'h2222, 0);
        // zero-count REG packet
        tbl[14] = mk(1, 16'h8000, 3'b000, 8'h00, 16'h0000, 1);
        tbl[15] = mk(1, 16'h0005, 3'b000, 8'h00, 16'h0000, 0);
        tbl[16] = mk(0, 16'h0000, 3'b000, 8'h00, 16'h0000, 0);
        // gapped 4-word IMEM packet at 0x20
        tbl[17] = mk(1, 16'h0004, 3'b000, 8'h00, 16'h0000, 1);
        tbl[18] = mk(0, 16'hFFFF, 3'b000, 8'h00, 16'h0000, 1);
        tbl[19] = mk(1, 16'h0020, 3'b000, 8'h00, 16'h0000, 1);
        tbl[20] = mk(0, 16'hFFFF, 3'b000, 8'h00, 16'h0000, 1);
        tbl[21] = mk(1, 16'h1001, 3'b001, 8'h20, 16'h1001, 1);
        tbl[22] = mk(0, 16'hFFFF, 3'b000, 8'h00, 16'h0000, 1);
        tbl[23] = mk(1, 16'h1002, 3'b001, 8'h22, 16'h1002, 1);
        tbl[24] = mk(0, 16'hFFFF, 3'b000, 8'h00, 16'h0000, 1);
        tbl[25] = mk(1, 16'h1003, 3'b001, 8'h24, 16'h1003, 1);
        tbl[26] = mk(0, 16'hFFFF, 3'b000, 8'h00, 16'h0000, 1);
        tbl[27] = mk(1, 16'h1004, 3'b001, 8'h26, 16'h1004, 0);
        tbl[28] = mk(0, 16'h0000, 3'b000, 8'h00, 16'h0000, 0);

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", in_ready, 0);
        chk("rst.hold", cpu_hold, 1);
        chk("rst.busy", busy, 0);
        chk("rst.we", {reg_we, dmem_we, imem_we}, 0);
        chk("rst.iaddr", imem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle.ready", in_ready, 1);
        chk("idle.hold", cpu_hold, 1);
        chk("idle.busy", busy, 0);
        chk("idle.we", {reg_we, dmem_we, imem_we}, 0);

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].v, tbl[i].d);
            check_vec(i, tbl[i]);
        end
        step(0, 16'h0000);
        chk("imem.count", imem_writes, 7);
        chk("dm[FE]", dm[8'hFE], 8'h12);
        chk("dm[FF]", dm[8'hFF], 8'h34);
        chk("dm[00]", dm[8'h00], 8'h56);
        chk("dm[01]", dm[8'h01], 8'h78);
        chk("rf[15]", rf[15], 16'h1111);
        chk("rf[0]", rf[0], 16'h2222);

        // Reset mid-DATA: strobe cleared asynchronously, packet dropped
        step(1, 16'h0002);
        step(1, 16'h0040);
        step(1, 16'hBEEF);
        chk("mid.we_before", imem_we, 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid.we_async", imem_we, 0);
        chk("mid.iaddr", imem_addr, 0);
        chk("mid.busy", busy, 0);
        chk("mid.hold", cpu_hold, 1);
        chk("mid.ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.ready_after", in_ready, 1);
        // Next word must be treated as a header, not a data beat
        step(1, 16'h4001);
        chk("mid.hdr_nowe", {reg_we, dmem_we, imem_we}, 0);
        chk("mid.hdr_busy", busy, 1);
        step(1, 16'h0031);
        step(1, 16'hAAAA);
        chk("mid.dwe", dmem_we, 1);
        chk("mid.daddr", dmem_addr, 8'h30);
        chk("mid.ddata", dmem_wdata, 16'hAAAA);
        chk("mid.busy_end", busy, 0);

        // GO releases the CPU and closes the stream
        step(1, 16'hC000);
        chk("go.hold", cpu_hold, 0);
        chk("go.ready", in_ready, 0);
        chk("go.busy", busy, 0);
        chk("go.we", {reg_we, dmem_we, imem_we}, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 16'h0001 + 16'(i));
            chk("run.we", {reg_we, dmem_we, imem_we}, 0);
            chk("run.ready", in_ready, 0);
            chk("run.hold", cpu_hold, 0);
        end
        chk("run.dm30", {dm[8'h30], dm[8'h31]}, 16'hAAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
